min_arbiter: RTL and testbench

MIN_ARBITER -- requirements
Module: min_arbiter

---
 rtl/min_pkg.sv | 20 ++
 rtl/min3_select.sv | 28 ++
 rtl/min_arbiter.sv | 133 +++++++++++++
 tb/tb_min_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/min_pkg.sv
// Shared constants and types for the min-channel arbiter.
package min_pkg;

  localparam int unsigned CHAN_W = 10;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] IDX_RED   = 2'd0;
  localparam logic [1:0] IDX_GREEN = 2'd1;
  localparam logic [1:0] IDX_BLUE  = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef struct packed {
    logic [CHAN_W-1:0] red;
    logic [CHAN_W-1:0] green;
    logic [CHAN_W-1:0] blue;
  } pixel_t;

endpackage

// File: rtl/min3_select.sv
// Combinational minimum-of-three channel selector; ties favour the lower index.
module min3_select
  import min_pkg::*;
(
  input  logic [CHAN_W-1:0] red,
  input  logic [CHAN_W-1:0] green,
  input  logic [CHAN_W-1:0] blue,
  output logic [CHAN_W-1:0] value,
  output logic [1:0]        index
);

  // Priority compare: red, then green, then blue (<= keeps ties on the lower index).
  always_comb begin
    value = red;
    index = IDX_RED;
    if (red <= green && red <= blue) begin
      value = red;
      index = IDX_RED;
    end else if (green <= blue) begin
      value = green;
      index = IDX_GREEN;
    end else begin
      value = blue;
      index = IDX_BLUE;
    end
  end

endmodule

// File: rtl/min_arbiter.sv
// Two-requester round-robin arbiter feeding a two-stage min-channel pipeline,
// with per-source delivered-result counters.
module min_arbiter
  import min_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [CHAN_W-1:0] a_red,
  input  logic [CHAN_W-1:0] a_green,
  input  logic [CHAN_W-1:0] a_blue,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [CHAN_W-1:0] b_red,
  input  logic [CHAN_W-1:0] b_green,
  input  logic [CHAN_W-1:0] b_blue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAN_W-1:0] out_value,
  output logic [1:0]        out_index,
  output logic              out_src,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b
);

  logic   adv;
  logic   grant_a;
  logic   grant_b;
  logic   a_fire;
  logic   b_fire;
  logic   in_fire;
  logic   out_fire;
  logic   last_grant;
  pixel_t pix_a;
  pixel_t pix_b;

  logic   s1_valid;
  pixel_t s1_pix;
  logic   s1_src;

  logic [CHAN_W-1:0] sel_value;
  logic [1:0]        sel_index;

  assign pix_a = '{red: a_red, green: a_green, blue: a_blue};
  assign pix_b = '{red: b_red, green: b_green, blue: b_blue};

  assign adv = !out_valid || out_ready;

  // Round-robin grant; with nothing requesting, A holds the grant. Grants depend on
  // the requesters' valids, but this block never derives a valid from a ready.
  always_comb begin
    grant_a = 1'b1;
    if (a_valid && b_valid) begin
      grant_a = (last_grant == SRC_B);
    end else if (b_valid) begin
      grant_a = 1'b0;
    end
  end

  assign grant_b  = !grant_a;
  assign a_ready  = !rst && adv && grant_a;
  assign b_ready  = !rst && adv && grant_b;
  assign a_fire   = a_valid && a_ready;
  assign b_fire   = b_valid && b_ready;
  assign in_fire  = a_fire || b_fire;
  assign out_fire = out_valid && out_ready;

  // Round-robin history moves only on an accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_B;
    end else if (in_fire) begin
      last_grant <= b_fire ? SRC_B : SRC_A;
    end
  end

  // Stage 1: capture the granted pixel and its source.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_src   <= SRC_A;
    end else if (adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_pix <= b_fire ? pix_b : pix_a;
        s1_src <= b_fire ? SRC_B : SRC_A;
      end
    end
  end

  min3_select u_min3_select (
    .red   (s1_pix.red),
    .green (s1_pix.green),
    .blue  (s1_pix.blue),
    .value (sel_value),
    .index (sel_index)
  );

  // Stage 2: register the selected minimum; a stage-1 bubble clears out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_index <= IDX_RED;
      out_src   <= SRC_A;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_value <= sel_value;
        out_index <= sel_index;
        out_src   <= s1_src;
      end
    end
  end

  // Delivered-result counters; clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (out_fire) begin
      if (out_src == SRC_A) begin
        cnt_a <= cnt_a + CNT_W'(1);
      end else begin
        cnt_b <= cnt_b + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_min_arbiter.sv
// Directed self-checking bench for min_arbiter.
module tb_min_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid, a_ready;
  logic [9:0] a_red, a_green, a_blue;
  logic       b_valid, b_ready;
  logic [9:0] b_red, b_green, b_blue;
  logic       out_valid, out_ready;
  logic [9:0] out_value;
  logic [1:0] out_index;
  logic       out_src;
  logic       clr_cnt;
  logic [15:0] cnt_a, cnt_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] exp_a = '0;
  logic [15:0] exp_b = '0;

  min_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_red     (a_red),
    .a_green   (a_green),
    .a_blue    (a_blue),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_red     (b_red),
    .b_green   (b_green),
    .b_blue    (b_blue),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_index (out_index),
    .out_src   (out_src),
    .clr_cnt   (clr_cnt),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_px(input logic [9:0] ar, ag, ab, br, bg, bb);
    a_red = ar; a_green = ag; a_blue = ab;
    b_red = br; b_green = bg; b_blue = bb;
  endtask

  // Single isolated transfer from one source; expects an empty pipeline and out_ready=1.
  task automatic send_px(input logic src, input logic [9:0] r, g, b,
                         input logic [9:0] ev, input logic [1:0] ei,
                         input string tag, input logic clr_at_out);
    set_px(r, g, b, r, g, b);
    a_valid = !src;
    b_valid = src;
    #1;
    check({tag, " ready"}, src ? b_ready : a_ready, 1);
    check({tag, " other_ready"}, src ? a_ready : b_ready, 0);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    check({tag, " t+1 out_valid"}, out_valid, 0);
    step();
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " out_value"}, out_value, ev);
    check({tag, " out_index"}, out_index, ei);
    check({tag, " out_src"}, out_src, src);
    clr_cnt = clr_at_out;
    step();
    clr_cnt = 1'b0;
    if (clr_at_out) begin
      exp_a = '0;
      exp_b = '0;
    end else if (src) begin
      exp_b++;
    end else begin
      exp_a++;
    end
    check({tag, " cnt_a"}, cnt_a, exp_a);
    check({tag, " cnt_b"}, cnt_b, exp_b);
    check({tag, " drained"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    set_px(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    step();

    // Reset state
    check("rst out_valid", out_valid, 0);
    check("rst out_value", out_value, 0);
    check("rst out_index", out_index, 0);
    check("rst out_src", out_src, 0);
    check("rst cnt_a", cnt_a, 0);
    check("rst cnt_b", cnt_b, 0);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("rst a_ready", a_ready, 0);
    check("rst b_ready", b_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst = 1'b0;

    // A only, green minimum
    send_px(1'b0, 10'd100, 10'd50, 10'd200, 10'd50, 2'd1, "a_basic", 1'b0);

    // Tie handling
    send_px(1'b0, 10'd7, 10'd7, 10'd7, 10'd7, 2'd0, "tie_777", 1'b0);
    send_px(1'b0, 10'd9, 10'd3, 10'd3, 10'd3, 2'd1, "tie_933", 1'b0);
    send_px(1'b0, 10'd0, 10'd1023, 10'd0, 10'd0, 2'd0, "tie_0_1023_0", 1'b0);
    send_px(1'b0, 10'd1023, 10'd1023, 10'd5, 10'd5, 2'd2, "tie_blue", 1'b0);

    // B only; leaves last grant on B so A wins the next contention
    send_px(1'b1, 10'd5, 10'd6, 10'd7, 10'd5, 2'd0, "b_only", 1'b0);

    // Both valid for 6 cycles: A,B,A,B,A,B and one result per cycle
    set_px(40, 50, 60, 90, 80, 70);
    for (int k = 0; k < 9; k++) begin
      a_valid = (k < 6);
      b_valid = (k < 6);
      #1;
      if (k < 6) begin
        check($sformatf("rr%0d a_ready", k), a_ready, (k % 2 == 0));
        check($sformatf("rr%0d b_ready", k), b_ready, (k % 2 == 1));
      end
      if (k >= 2 && k < 8) begin
        check($sformatf("rr%0d out_valid", k), out_valid, 1);
        check($sformatf("rr%0d out_src", k), out_src, (k % 2 == 1));
        check($sformatf("rr%0d out_value", k), out_value, (k % 2 == 0) ? 40 : 70);
        check($sformatf("rr%0d out_index", k), out_index, (k % 2 == 0) ? 0 : 2);
      end else begin
        check($sformatf("rr%0d out_valid", k), out_valid, 0);
      end
      if (k < 8) step();
    end
    exp_a += 3;
    exp_b += 3;
    check("rr cnt_a", cnt_a, exp_a);
    check("rr cnt_b", cnt_b, exp_b);

    // Stall with both requesters pending
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("stall pre a_ready", a_ready, 1);
    step();
    check("stall pre b_ready", b_ready, 1);
    step();
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d out_valid", k), out_valid, 1);
      check($sformatf("stall%0d out_src", k), out_src, 0);
      check($sformatf("stall%0d out_value", k), out_value, 40);
      check($sformatf("stall%0d a_ready", k), a_ready, 0);
      check($sformatf("stall%0d b_ready", k), b_ready, 0);
      step();
    end
    check("stall cnt_a held", cnt_a, exp_a);
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("release out_src", out_src, 0);
    check("release out_value", out_value, 40);
    step();
    check("release2 out_valid", out_valid, 1);
    check("release2 out_src", out_src, 1);
    check("release2 out_value", out_value, 70);
    step();
    check("release3 out_valid", out_valid, 0);
    exp_a++;
    exp_b++;
    check("release cnt_a", cnt_a, exp_a);
    check("release cnt_b", cnt_b, exp_b);

    // Reset with both stages full
    a_valid = 1'b1; b_valid = 1'b1;
    step();
    step();
    check("midrst full", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst a_ready", a_ready, 0);
    check("midrst b_ready", b_ready, 0);
    step();
    exp_a = '0;
    exp_b = '0;
    check("midrst out_valid", out_valid, 0);
    check("midrst cnt_a", cnt_a, 0);
    check("midrst cnt_b", cnt_b, 0);
    rst = 1'b0;
    set_px(11, 22, 33, 90, 80, 70);
    #1;
    check("postrst a_ready", a_ready, 1);
    check("postrst b_ready", b_ready, 0);
    step();
    check("postrst t1 out_valid", out_valid, 0);
    check("postrst t1 b_ready", b_ready, 1);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check("postrst out_valid", out_valid, 1);
    check("postrst out_src", out_src, 0);
    check("postrst out_value", out_value, 11);
    step();
    check("postrst2 out_src", out_src, 1);
    check("postrst2 out_value", out_value, 70);
    step();
    check("postrst3 out_valid", out_valid, 0);
    exp_a++;
    exp_b++;
    check("postrst cnt_a", cnt_a, exp_a);
    check("postrst cnt_b", cnt_b, exp_b);

    // Counter clear, preload to 0xFFFF, wrap, clear beating increment
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    exp_a = '0;
    exp_b = '0;
    check("clr cnt_a", cnt_a, 0);
    check("clr cnt_b", cnt_b, 0);
    set_px(1, 2, 3, 1, 2, 3);
    a_valid = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    a_valid = 1'b0;
    step();
    step();
    step();
    exp_a = 16'hFFFF;
    check("preload cnt_a", cnt_a, 16'hFFFF);
    send_px(1'b0, 10'd4, 10'd5, 10'd6, 10'd4, 2'd0, "wrap", 1'b0);
    send_px(1'b0, 10'd4, 10'd5, 10'd6, 10'd4, 2'd0, "after_wrap", 1'b0);
    send_px(1'b0, 10'd4, 10'd5, 10'd6, 10'd4, 2'd0, "clr_wins", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
